// File: rtl/univ_shift_reg.sv
// univ_shift_reg
//   WIDTH-bit universal register: hold, shift left/right, rotate left/right,
//   arithmetic shift right, parallel load, and a self-timed serialise burst.
//   A burst loads d and shifts it out LSB-first on sout_lsb. busy is high
//   while the burst runs, and done pulses for one cycle when it completes.
//
// Ports
//   clk       clock, rising edge
//   rst       synchronous active-high reset, loads RST_VAL
//   pst_n     synchronous active-low preset, loads PST_VAL and aborts a burst
//   en        mode enable (ignored while busy)
//   mode      operation select
//   d         parallel load data
//   sin_l     serial in to MSB (right shifts, burst)
//   sin_r     serial in to LSB (left shifts)
//   q, qb     register contents and complement
//   sout_lsb  q[0]
//   sout_msb  q[WIDTH-1]
//   busy      burst in progress
//   done      one-cycle burst-complete pulse
//
// state | meaning
// IDLE  | normal register operation under en/mode
// SHIFT | serialise burst, one bit per cycle until cnt reaches 0

module univ_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] PST_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             sout_lsb,
  output logic             sout_msb,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= RST_VAL;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (!pst_n) begin
      state_d = IDLE;
      q_d     = PST_VAL;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      // cnt counts the shifts still owed; the cnt==0 cycle only closes the burst
      if (cnt_q != '0) begin
        q_d   = {sin_l, q_q[WIDTH-1:1]};
        cnt_d = cnt_q - CW'(1);
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (en) begin
      case (mode)
        3'b000: q_d = q_q;
        3'b001: q_d = {sin_l, q_q[WIDTH-1:1]};
        3'b010: q_d = {q_q[WIDTH-2:0], sin_r};
        3'b011: q_d = d;
        3'b100: q_d = {q_q[0], q_q[WIDTH-1:1]};
        3'b101: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        3'b110: q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        3'b111: begin
          q_d     = d;
          cnt_d   = CW'(WIDTH - 1);
          state_d = SHIFT;
        end
        default: q_d = q_q;
      endcase
    end
  end

  assign q        = q_q;
  assign qb       = ~q_q;
  assign sout_lsb = q_q[0];
  assign sout_msb = q_q[WIDTH-1];
  assign busy     = (state_q == SHIFT);
  assign done     = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst, pst_n, en, sin_l, sin_r;
  logic [2:0] mode;
  logic [7:0] d;
  logic [7:0] q, qb;
  logic       sout_lsb, sout_msb, busy, done;

  int vectors    = 0;
  int miscompares = 0;

  univ_shift_reg #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .pst_n(pst_n), .en(en), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .q(q), .qb(qb), .sout_lsb(sout_lsb),
    .sout_msb(sout_msb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0]  word;
    logic [15:0] bits;
    int          nb, gap, saw_done, done_in_gap;

    rst = 1'b1; pst_n = 1'b0; en = 1'b0; mode = 3'b000;
    d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
    step(); step();
    chk("rst_q", q, 8'h00);
    chk("rst_qb", qb, 8'hFF);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_msb", sout_msb, 1'b0);

    rst = 1'b0;
    step();
    chk("preset_q", q, 8'hFF);
    chk("preset_lsb", sout_lsb, 1'b1);

    pst_n = 1'b1; en = 1'b1; mode = 3'b011; d = 8'hA5;
    step();
    chk("load_a5", q, 8'hA5);
    mode = 3'b001; sin_l = 1'b1;
    step();
    chk("shr_sin1", q, 8'hD2);
    mode = 3'b010; sin_r = 1'b0;
    step();
    chk("shl_sin0", q, 8'hA4);

    mode = 3'b011; d = 8'h81; step();
    mode = 3'b100; step();
    chk("rotr_81", q, 8'hC0);
    mode = 3'b011; d = 8'h81; step();
    mode = 3'b101; step();
    chk("rotl_81", q, 8'h03);
    mode = 3'b011; d = 8'h80; step();
    chk("msb_80", sout_msb, 1'b1);
    mode = 3'b110; step();
    chk("asr_80", q, 8'hC0);

    en = 1'b0; mode = 3'b011; d = 8'h55;
    step(); step();
    chk("hold_en0", q, 8'hC0);

    rst = 1'b1; pst_n = 1'b0;
    step();
    chk("rst_beats_pst", q, 8'h00);
    rst = 1'b0; pst_n = 1'b1;

    // serialise 0xB4 with a load attempt during the burst
    word = 8'hB4;
    en = 1'b1; mode = 3'b111; d = word; sin_l = 1'b0;
    step();
    mode = 3'b011; d = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("burst_bit%0d", k), sout_lsb, word[k]);
      chk($sformatf("burst_busy%0d", k), busy, 1'b1);
      chk($sformatf("burst_nodone%0d", k), done, 1'b0);
      step();
    end
    en = 1'b0;
    chk("burst_end_busy", busy, 1'b0);
    chk("burst_end_done", done, 1'b1);
    chk("burst_end_q", q, 8'h01);
    step();
    chk("done_one_cycle", done, 1'b0);

    // preset abort at the 4th burst cycle
    en = 1'b1; mode = 3'b111; d = 8'hB4;
    step();
    en = 1'b0;
    step(); step(); step();
    pst_n = 1'b0;
    step();
    pst_n = 1'b1;
    chk("abort_q", q, 8'hFF);
    chk("abort_busy", busy, 1'b0);
    saw_done = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) saw_done = 1;
      step();
    end
    chk("abort_no_done", saw_done, 0);

    // back-to-back bursts, second start accepted in the done cycle
    en = 1'b1; mode = 3'b111; d = 8'h0F; sin_l = 1'b0;
    step();
    d = 8'hF0;
    bits = '0; nb = 0; gap = 0; done_in_gap = 0;
    for (int i = 0; i < 18; i++) begin
      if (busy) begin
        if (nb < 16) bits[nb] = sout_lsb;
        nb++;
        if (nb > 8) en = 1'b0;
      end else if (nb == 8) begin
        gap++;
        if (done) done_in_gap = 1;
      end
      step();
    end
    chk("b2b_nbits", nb, 16);
    chk("b2b_bits", bits, 16'hF00F);
    chk("b2b_gap", gap, 1);
    chk("b2b_done_gap", done_in_gap, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
